apb_master_ctrl: RTL and testbench
==================================

# apb_master_ctrl

Synthesizable APB initiator that turns single-beat commands on a valid/ready command port into APB SETUP/ACCESS transfers, honours `pready` wait states, and returns read data and error status on a one-cycle response strobe. It sits between an on-chip controller (sequencer or register-programming engine) and APB responders such as the timer block. It is the RTL counterpart of the bench CPU model. It drives the timer's TCR/TCNT registers without a testbench task layer.

## Interface
- ADDR_W, 8, APB address width
- DATA_W, 8, APB data width
- TIMEOUT, 255, max ACCESS cycles with `pready` low before forced abort; 0 disables the timeout
- pclk  in  1  APB clock; all state on rising edge
- presetn  in  1  reset, asynchronous assert, active-low, synchronous deassert from the system reset generator
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when `cmd_valid & cmd_ready` at a rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err  out  1  `pslverr` sampled at completion, or 1 on timeout
- rsp_timeout  out  1  completion caused by timeout
- paddr, pwrite, pwdata  out  ADDR_W / 1 / DATA_W  APB address/control, registered
- psel, penable  out  1  APB phase controls, registered
- prdata  in  DATA_W; pready  in  1; pslverr  in  1  APB responder returns

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - `cmd_ready` = 1.
  - On handshake, capture addr/write/wdata into `paddr`/`pwrite`/`pwdata`, then go to SETUP.
- SETUP: `psel`=1, `penable`=0, `cmd_ready`=0; always go to ACCESS next.
- ACCESS: `psel`=1, `penable`=1.
  - With `pready`=0: stay in ACCESS, increment the wait counter.
  - With `pready`=1: transfer completes at this edge.
    - Register `rsp_rdata` = `prdata` (reads only) and `rsp_err` = `pslverr`.
    - `cmd_ready` = 1 in this cycle.
    - If a command handshakes at the same edge, go straight to SETUP with the new command (back-to-back; `psel` stays 1, `penable` drops). Otherwise go to IDLE.
- Timeout:
  - Applies when TIMEOUT≠0 and the wait counter reaches TIMEOUT with `pready` still 0.
  - Abort to IDLE and respond with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - `cmd_ready` is 0 in the abort cycle.
- Wait counter: width `$clog2(TIMEOUT+1)`, cleared on entry to SETUP, saturating.
- `paddr`/`pwrite`/`pwdata` hold stable from SETUP through the completing ACCESS cycle. Outside a transfer they keep their last value.
- No response backpressure: the consumer must take `rsp_*` in the `rsp_valid` cycle.

## Timing
- Reset values: state IDLE, `psel`=0, `penable`=0, `paddr`=0, `pwrite`=0, `pwdata`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `rsp_timeout`=0, wait counter 0.
- Reset assertion mid-transfer drops `psel`/`penable` immediately, without waiting for a clock edge. The in-flight command produces no response.
- Zero-wait transfer, command accepted at edge E:
  - SETUP in cycle E+1, ACCESS in cycle E+2.
  - `rsp_valid` high in cycle E+3 for exactly 1 cycle.
- Each responder wait state adds 1 cycle.
- Back-to-back zero-wait throughput: one transfer per 2 cycles.
- `rsp_*` fields are valid only while `rsp_valid`=1. `rsp_err`/`rsp_timeout` return to 0 the cycle after.
- With TIMEOUT=N: abort after the Nth consecutive ACCESS cycle with `pready`=0. `rsp_valid` follows 1 cycle later.

## Structure
- Shared package `apb_pkg`:
  - FSM state encoding: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
  - Shared APB width constants.
  - Timer register address constants: TCR=8'h01 (bit 4 = count-up enable) and the TCNT address.
- Optional sub-module `apb_wait_cnt`: saturating wait counter with clear/increment/hit outputs.
- Everything else stays in one flat module.

## Test plan
- Reset: hold `presetn`=0 → all outputs at reset values, `cmd_ready`=1 after release.
- Write then read to the timer:
  - Write 8'h10 to addr 8'h01 → `pwdata`=8'h10 in SETUP/ACCESS.
  - Read of 8'h01 → `rsp_rdata`=8'h10, `rsp_err`=0.
  - Read latency is 3 cycles from acceptance.
- Wait states: responder holds `pready`=0 for 3 cycles on a read returning 8'hA5 → `rsp_valid` 6 cycles after acceptance, `rsp_rdata`=8'hA5.
- Back-to-back: two writes (8'h10, 8'h00 to 8'h01) with `cmd_valid` held high → second SETUP directly follows first ACCESS, `psel` never drops, two `rsp_valid` pulses 2 cycles apart.
- Error and timeout:
  - `pslverr`=1 on completion → `rsp_err`=1, `rsp_timeout`=0.
  - TIMEOUT=4 with `pready` stuck 0 → abort after 4 ACCESS cycles, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0, `psel`=0.
- Reset mid-ACCESS: assert `presetn`=0 during a wait state → `psel`/`penable` drop without a clock edge, no `rsp_valid`, next command runs normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encoding, bus widths and timer register map.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  // Timer block register map
  localparam logic [7:0] TCR_ADDR       = 8'h01;
  localparam logic [7:0] TCNT_ADDR      = 8'h02;
  localparam int         TCR_CNT_UP_BIT = 4;

endpackage

// File: rtl/apb_wait_cnt.sv
// Saturating ACCESS wait-state counter; hit_o flags the cycle in which one
// more wait state would reach TIMEOUT (never asserted when TIMEOUT is 0).
module apb_wait_cnt
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam int               CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit               TO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment, increment saturates at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = TO_EN && (cnt_q == LAST);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB initiator: converts single-beat valid/ready commands into APB
// SETUP/ACCESS transfers and returns a one-cycle response strobe.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              cmd_ready_s;
  logic              cnt_clr_s;
  logic              cnt_inc_s;
  logic              cnt_hit_s;

  apb_wait_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_cnt (
    .clk   (pclk),
    .rst_n (presetn),
    .clr_i (cnt_clr_s),
    .inc_i (cnt_inc_s),
    .hit_o (cnt_hit_s)
  );

  // Next-state, APB phase and response logic; psel/penable_d describe the next state
  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    psel_d        = 1'b0;
    penable_d     = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    cmd_ready_s   = 1'b0;
    cnt_clr_s     = 1'b0;
    cnt_inc_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          cnt_clr_s = 1'b1;
          state_d   = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          cmd_ready_s = 1'b1;
          if (cmd_valid) begin
            // Back-to-back: psel stays high, penable drops for the new SETUP
            paddr_d   = cmd_addr;
            pwrite_d  = cmd_write;
            pwdata_d  = cmd_wdata;
            psel_d    = 1'b1;
            cnt_clr_s = 1'b1;
            state_d   = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_hit_s) begin
          // Responder never answered: abort and report a timeout
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_inc_s = 1'b1;
          psel_d    = 1'b1;
          penable_d = 1'b1;
          state_d   = ST_ACCESS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, APB and response registers; async reset drops psel/penable at once
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= ST_IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_s;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with a small APB responder model.
module tb_apb_master_ctrl;

  logic       pclk;
  logic       presetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic [7:0] paddr;
  logic       pwrite;
  logic [7:0] pwdata;
  logic       psel;
  logic       penable;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  // Responder model controls
  int         wait_cfg;
  logic       stuck;
  logic       err_cfg;
  int         acc_cnt;
  logic [7:0] mem [0:255];

  int n_err;
  int n_chk;

  apb_master_ctrl #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .TIMEOUT (4)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .psel        (psel),
    .penable     (penable),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  assign pready  = psel && penable && !stuck && (acc_cnt >= wait_cfg);
  assign prdata  = mem[paddr];
  assign pslverr = err_cfg;

  // Count ACCESS wait cycles of the current transfer
  always @(posedge pclk or negedge presetn) begin
    if (!presetn) acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  // Responder register file write port
  always @(posedge pclk) begin
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One command; latency is counted in cycles after the accepting edge
  task automatic do_xfer(input string tag, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input int exp_lat,
                         input logic [7:0] exp_rdata, input logic exp_err,
                         input logic exp_to);
    int lat;
    bit seen;
    @(posedge pclk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(negedge pclk);
    check({tag, "_ready"}, cmd_ready, 1);
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge pclk);
      lat++;
      if (lat == 1) begin
        check({tag, "_setup_psel"}, psel, 1);
        check({tag, "_setup_pen"}, penable, 0);
        check({tag, "_paddr"}, paddr, addr);
        check({tag, "_pwrite"}, pwrite, wr);
        if (wr) check({tag, "_pwdata"}, pwdata, wdata);
      end
      if (lat == 2) begin
        check({tag, "_access_pen"}, penable, 1);
        if (wr) check({tag, "_pwdata_acc"}, pwdata, wdata);
      end
      if (rsp_valid) seen = 1;
    end
    check({tag, "_latency"}, lat, exp_lat);
    if (seen) begin
      check({tag, "_rdata"}, rsp_rdata, exp_rdata);
      check({tag, "_err"}, rsp_err, exp_err);
      check({tag, "_to"}, rsp_timeout, exp_to);
      if (exp_to) check({tag, "_abort_psel"}, psel, 0);
    end
    @(negedge pclk);
    check({tag, "_valid_drop"}, rsp_valid, 0);
    check({tag, "_err_drop"}, rsp_err, 0);
    check({tag, "_to_drop"}, rsp_timeout, 0);
  endtask

  initial begin
    logic [4:0] exp_psel;
    logic [4:0] exp_pen;
    logic [4:0] exp_rv;
    n_err = 0; n_chk = 0;
    wait_cfg = 0; stuck = 1'b0; err_cfg = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    presetn = 1'b0;

    // Reset values
    repeat (2) @(negedge pclk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_to", rsp_timeout, 0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(negedge pclk);
    check("rst_cmd_ready", cmd_ready, 1);

    // Timer TCR write then read back, zero wait states
    do_xfer("wr_tcr", 1'b1, 8'h01, 8'h10, 3, 8'h00, 1'b0, 1'b0);
    do_xfer("rd_tcr", 1'b0, 8'h01, 8'h00, 3, 8'h10, 1'b0, 1'b0);

    // Three wait states on a read returning A5
    do_xfer("wr_a5", 1'b1, 8'h03, 8'hA5, 3, 8'h00, 1'b0, 1'b0);
    wait_cfg = 3;
    do_xfer("rd_wait", 1'b0, 8'h03, 8'h00, 6, 8'hA5, 1'b0, 1'b0);
    wait_cfg = 0;

    // Back-to-back writes with cmd_valid held high
    exp_psel = 5'b01111;  // bit i-1 = cycle i after acceptance
    exp_pen  = 5'b01010;
    exp_rv   = 5'b10100;
    @(posedge pclk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 8'h10;
    @(posedge pclk); #1;
    cmd_wdata = 8'h00;
    for (int i = 1; i <= 5; i++) begin
      @(negedge pclk);
      check($sformatf("b2b_psel_c%0d", i), psel, exp_psel[i-1]);
      check($sformatf("b2b_pen_c%0d", i), penable, exp_pen[i-1]);
      check($sformatf("b2b_rv_c%0d", i), rsp_valid, exp_rv[i-1]);
      if (i == 1) check("b2b_pwdata1", pwdata, 8'h10);
      if (i == 3) check("b2b_pwdata2", pwdata, 8'h00);
      @(posedge pclk); #1;
      if (i == 2) cmd_valid = 1'b0;
    end

    // Slave error on completion
    err_cfg = 1'b1;
    do_xfer("slverr", 1'b1, 8'h02, 8'h55, 3, 8'h00, 1'b1, 1'b0);
    err_cfg = 1'b0;

    // pready stuck low: abort after 4 ACCESS cycles
    stuck = 1'b1;
    do_xfer("timeout", 1'b0, 8'h03, 8'h00, 6, 8'h00, 1'b1, 1'b1);
    stuck = 1'b0;

    // Reset asserted during an ACCESS wait state
    wait_cfg = 10;
    @(posedge pclk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h03;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    check("mid_pen_before", penable, 1);
    #2 presetn = 1'b0;
    #1;
    check("mid_psel_async", psel, 0);
    check("mid_pen_async", penable, 0);
    repeat (3) begin
      @(negedge pclk);
      check("mid_rv_in_rst", rsp_valid, 0);
    end
    @(posedge pclk); #1;
    presetn = 1'b1;
    wait_cfg = 0;
    repeat (3) begin
      @(negedge pclk);
      check("mid_rv_after", rsp_valid, 0);
    end
    check("mid_cmd_ready", cmd_ready, 1);
    do_xfer("post_rst", 1'b0, 8'h03, 8'h00, 3, 8'hA5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
